// File: rtl/serial_frame_tx_if.sv
// ---------------------------------------------------------------------------
// serial_frame_tx_if
//
// Bundles the word-side handshake and the serial-side outputs of
// serial_frame_tx.
//   data_in[3:0]     word to transmit, bit 3 goes out first
//   data_valid       data_in is valid this cycle
//   data_ready       transmitter accepts data_in this cycle (combinational)
//   out              serial bit stream, one frame bit every cycle
//   frame_start      high while out carries bit 3 of a frame
//   data_frame       high for every cycle of a frame sourced from data_in
//   frames_sent[7:0] number of data frames loaded, wraps at 256
//
// Modports:
//   master - the upstream word source (drives data_in/data_valid)
//   slave  - the transmitter itself
// ---------------------------------------------------------------------------
interface serial_frame_tx_if;
    logic [3:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       out;
    logic       frame_start;
    logic       data_frame;
    logic [7:0] frames_sent;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  out,
        input  frame_start,
        input  data_frame,
        input  frames_sent
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output out,
        output frame_start,
        output data_frame,
        output frames_sent
    );
endinterface

// File: rtl/serial_frame_tx.sv
// ---------------------------------------------------------------------------
// serial_frame_tx
//
// Serialises 4-bit words MSB-first into a contiguous, frame-aligned bit
// stream for a downstream 4-bit sequence detector. The line is never idle:
// a frame is four consecutive cycles, and when no word is available a
// filler frame (FILL) is sent instead.
//
// A one-word holding register decouples the word handshake from the frame
// boundary, so a word may be accepted in any slot. A word accepted on the
// last slot of a frame with the holding register empty bypasses straight
// into the shift register, which gives one word per frame when data_valid
// stays high.
//
// Parameters:
//   FILL   filler frame pattern, must not match the detector's pattern
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_frame_tx_if.slave (word handshake + serial outputs)
// ---------------------------------------------------------------------------
module serial_frame_tx #(
    parameter logic [3:0] FILL = 4'b0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_frame_tx_if.slave         bus
);

    logic [3:0] shreg_q,       shreg_d;
    logic [1:0] slot_q,        slot_d;
    logic [3:0] hold_q,        hold_d;
    logic       hold_full_q,   hold_full_d;
    logic       cur_data_q,    cur_data_d;
    logic [7:0] frames_sent_q, frames_sent_d;

    logic       last_slot;
    logic       ready;
    logic       accept;
    logic       load_data;

    assign last_slot = (slot_q == 2'd3);

    // The holding register frees up on the last slot of a frame because it
    // drains into the shift register on that same edge.
    assign ready  = ~hold_full_q | last_slot;
    assign accept = bus.data_valid & ready;

    always_comb begin
        slot_d        = 2'(slot_q + 2'd1);
        shreg_d       = {shreg_q[2:0], 1'b0};
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        cur_data_d    = cur_data_q;
        frames_sent_d = frames_sent_q;
        load_data     = 1'b0;

        if (last_slot) begin
            // Frame boundary: the held word has priority over a new word,
            // which in turn has priority over filler.
            if (hold_full_q) begin
                shreg_d   = hold_q;
                load_data = 1'b1;
                if (accept) begin
                    // Drain and refill on the same edge.
                    hold_d      = bus.data_in;
                    hold_full_d = 1'b1;
                end else begin
                    hold_full_d = 1'b0;
                end
            end else if (accept) begin
                shreg_d   = bus.data_in;
                load_data = 1'b1;
            end else begin
                shreg_d = FILL;
            end

            cur_data_d = load_data;
            if (load_data) begin
                frames_sent_d = 8'(frames_sent_q + 8'd1);
            end
        end else if (accept) begin
            hold_d      = bus.data_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q       <= FILL;
            slot_q        <= 2'd0;
            hold_q        <= 4'd0;
            hold_full_q   <= 1'b0;
            cur_data_q    <= 1'b0;
            frames_sent_q <= 8'd0;
        end else begin
            shreg_q       <= shreg_d;
            slot_q        <= slot_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            cur_data_q    <= cur_data_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    assign bus.data_ready  = ready;
    assign bus.out         = shreg_q[3];
    assign bus.frame_start = (slot_q == 2'd0);
    assign bus.data_frame  = cur_data_q;
    assign bus.frames_sent = frames_sent_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

    localparam logic [3:0] FILL_P = 4'b0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    serial_frame_tx_if bus();

    serial_frame_tx #(.FILL(FILL_P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int df_cycles = 0;

    // Reference model: a queue of accepted words waiting for a frame slot,
    // plus the frame currently on the line and the cycle position in it.
    logic [3:0] m_q[$];
    logic [3:0] m_frame;
    int         m_slot;
    bit         m_df;
    int         m_cnt;
    bit         last_ready;

    function automatic bit m_ready();
        return (m_q.size() == 0) || (m_slot == 3);
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_frame = FILL_P;
        m_slot  = 0;
        m_df    = 0;
        m_cnt   = 0;
    endtask

    task automatic m_edge(input bit v, input logic [3:0] d);
        if (v && m_ready()) m_q.push_back(d);
        if (m_slot == 3) begin
            if (m_q.size() > 0) begin
                m_frame = m_q.pop_front();
                m_df    = 1;
                m_cnt   = (m_cnt + 1) % 256;
            end else begin
                m_frame = FILL_P;
                m_df    = 0;
            end
        end
        m_slot = (m_slot + 1) % 4;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check data_ready before the edge,
    // advance the model with the edge, check registered outputs after it.
    task automatic step(input bit v, input logic [3:0] d, output bit acc);
        bit exp_rdy;
        bus.data_valid = v;
        bus.data_in    = d;
        exp_rdy = m_ready();
        @(negedge clk);
        last_ready = bus.data_ready;
        chk("data_ready", int'(bus.data_ready), int'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        m_edge(v, d);
        #1;
        chk("out", int'(bus.out), int'(m_frame[3 - m_slot]));
        chk("frame_start", int'(bus.frame_start), int'(m_slot == 0));
        chk("data_frame", int'(bus.data_frame), int'(m_df));
        chk("frames_sent", int'(bus.frames_sent), m_cnt);
        if (bus.data_frame) df_cycles++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = 4'h0;
        #1;
        m_reset();
        chk("rst_out", int'(bus.out), int'(FILL_P[3]));
        chk("rst_frame_start", int'(bus.frame_start), 1);
        chk("rst_data_frame", int'(bus.data_frame), 0);
        chk("rst_frames_sent", int'(bus.frames_sent), 0);
        chk("rst_data_ready", int'(bus.data_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, acc);
    endtask

    task automatic send_word(input logic [3:0] w);
        bit acc;
        acc = 0;
        for (int tries = 0; tries < 8 && !acc; tries++) step(1'b1, w, acc);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    typedef struct packed {
        bit         v;
        logic [3:0] d;
        bit         rdy;
        bit         o;
        bit         fs;
        bit         df;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl [0:12];
    logic [3:0] stream4 [0:3];

    initial begin
        bit acc;
        bit         rv;
        logic [3:0] rd;

        //          v     d      rdy   o     fs    df    cnt
        tbl[0]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
        tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[5]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
        tbl[6]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[7]  = '{1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2};
        tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
        tbl[9]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2};
        tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2};
        tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2};
        tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};

        stream4[0] = 4'b1011;
        stream4[1] = 4'b1010;
        stream4[2] = 4'b0011;
        stream4[3] = 4'b0010;

        bus.data_valid = 1'b0;
        bus.data_in    = 4'h0;

        // Idle line after reset: filler frames only.
        do_reset();
        idle(12);

        // Hold-path and bypass-path words, with a stalled offer in between.
        do_reset();
        for (int i = 0; i <= 12; i++) begin
            step(tbl[i].v, tbl[i].d, acc);
            chk($sformatf("tbl%0d_ready", i), int'(last_ready), int'(tbl[i].rdy));
            chk($sformatf("tbl%0d_out", i), int'(bus.out), int'(tbl[i].o));
            chk($sformatf("tbl%0d_fs", i), int'(bus.frame_start), int'(tbl[i].fs));
            chk($sformatf("tbl%0d_df", i), int'(bus.data_frame), int'(tbl[i].df));
            chk($sformatf("tbl%0d_cnt", i), int'(bus.frames_sent), int'(tbl[i].cnt));
        end

        // Back-to-back stream of four words: 16 data bits, no filler.
        do_reset();
        df_cycles = 0;
        for (int i = 0; i < 4; i++) send_word(stream4[i]);
        idle(8);
        chk("stream_data_cycles", df_cycles, 16);
        chk("stream_frames_sent", int'(bus.frames_sent), 4);

        // Reset during slot 2 of a data frame with a word held.
        do_reset();
        idle(3);
        step(1'b1, 4'b1011, acc);
        step(1'b1, 4'b0110, acc);
        step(1'b0, 4'h0, acc);
        chk("pre_rst_slot2", int'(bus.frame_start), 0);
        #1;
        do_reset();
        chk("post_rst_frames_sent", int'(bus.frames_sent), 0);
        df_cycles = 0;
        idle(8);
        chk("held_word_dropped", df_cycles, 0);

        // Randomised traffic against the model; a stalled offer stays stable.
        do_reset();
        rv = 0;
        rd = 4'h0;
        acc = 1;
        for (int i = 0; i < 600; i++) begin
            if (!(rv && !acc)) begin
                rv = ($urandom_range(0, 99) < 55);
                rd = 4'($urandom);
            end
            step(rv, rd, acc);
        end
        idle(8);

        // 256 loads wrap the frame counter back to zero.
        do_reset();
        for (int i = 0; i < 256; i++) send_word(4'($urandom));
        idle(8);
        chk("wrap_frames_sent", int'(bus.frames_sent), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Upstream stage: serialises 4-bit words MSB-first into the contiguous, frame-aligned bit stream consumed by the 4-bit sequence detector (detector samples one bit per cycle, frames back-to-back).

Interface
REQ-001 Parameter FILL, default 4'b0000, meaning filler frame sent when no word is available (must be a non-matching pattern).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 data_in  input  4  word to transmit, bit 3 sent first.
REQ-005 data_valid  input  1  data_in valid this cycle.
REQ-006 data_ready  output  1  block accepts data_in this cycle (combinational).
REQ-007 out  output  1  serial bit to detector input, registered.
REQ-008 frame_start  output  1  high while out carries bit 3 of a frame.
REQ-009 data_frame  output  1  high for all 4 cycles of a frame sourced from data_in, low for filler frames.
REQ-010 frames_sent  output  8  count of data frames loaded for transmission.

Function
REQ-011 The block SHALL hold shreg[3:0], slot[1:0], hold[3:0], hold_full, cur_data, frames_sent[7:0]; out = shreg[3], frame_start = (slot==0), data_frame = cur_data.
REQ-012 slot SHALL advance 0->1->2->3->0 every cycle unconditionally; out is never idle, every cycle is one frame bit.
REQ-013 On edges with slot!=3, shreg SHALL shift left by one (LSB filled 0).
REQ-014 On edges with slot==3, shreg SHALL load, in priority: hold if hold_full; else data_in if accepted this edge (bypass); else FILL.
REQ-015 cur_data SHALL be set at each slot-3 edge to 1 if a data word was loaded, else 0.
REQ-016 data_ready SHALL equal (!hold_full) | (slot==3).
REQ-017 Accept = data_valid & data_ready at a rising edge; data_in/data_valid are sampled only then.
REQ-018 Accept at slot!=3: hold<=data_in, hold_full<=1.
REQ-019 Accept at slot==3 with hold_full: shreg<=hold, hold<=data_in, hold_full stays 1 (simultaneous drain and fill).
REQ-020 Accept at slot==3 with hold empty: bypass to shreg, hold_full stays 0.
REQ-021 No accept at slot==3 with hold_full: hold_full<=0.
REQ-022 Latency: bypass word appears on out (bit 3) the cycle after the accepting edge; held word appears after the next slot-3 edge.
REQ-023 Sustained throughput SHALL be one word per 4 cycles with no filler between words when data_valid stays high.
REQ-024 frames_sent SHALL increment by 1 on every slot-3 edge that loads a data word, wrapping 255->0.
REQ-025 data_valid high while data_ready low: no state change, word stays on upstream side (upstream holds data_in stable).

Reset
REQ-026 While rst_n=0: shreg=FILL, slot=0, hold=0, hold_full=0, cur_data=0, frames_sent=0; hence out=FILL[3], frame_start=1, data_frame=0, data_ready=1.
REQ-027 Reset assertion mid-frame SHALL immediately discard the in-flight frame and held word; first frame after release is FILL starting at slot 0.
REQ-028 The first rising edge after rst_n rises SHALL advance slot 0->1.

Verification
REQ-029 Reset, no data_valid for 12 cycles -> out = FILL bits continuously, frame_start every 4th cycle, data_frame=0, frames_sent=0.
REQ-030 Present 4'b1011 during slot 3 with hold empty -> out = 1,0,1,1 in next 4 cycles, data_frame=1, frames_sent=1; detector dec=1 on 4th bit.
REQ-031 Stream 1011,1010,0011,0010 with data_valid held high -> 16 contiguous data bits, no filler, data_ready low in slots 0-2 once hold fills, frames_sent=4; detector dec pattern 1,1,1,0.
REQ-032 Accept 4'b1010 at slot 1 -> hold_full=1, data_ready=0 at slots 2,3? no: data_ready=0 at slot 2, 1 at slot 3; word on out starting next slot 0.
REQ-033 Assert rst_n=0 at slot 2 of a data frame with hold_full=1 -> out=FILL[3], frames_sent=0, held word never transmitted.
REQ-034 Send 256 data words -> frames_sent wraps to 0 after the 256th load.
